// File: rtl/oblivious_write_bank_pkg.sv
// oblivious_write_bank_pkg: shared FSM state encoding and address-width helper
package oblivious_write_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      SWEEP = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int aw_for(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/oblivious_write_bank_onehot_decode.sv
// onehot_decode: gate-only binary-to-one-hot decoder (addr_i -> sel_o, one bit per entry)
module onehot_decode
   import oblivious_write_bank_pkg::*;
#(
   parameter int AW    = 2,
   parameter int DEPTH = 4
) (
   input  logic [AW-1:0]    addr_i,
   output logic [DEPTH-1:0] sel_o
);

   // Each select bit is an AND of per-bit XNORs against the entry index;
   // indices >= DEPTH have no output bit, so out-of-range addresses select nothing.
   for (genvar i = 0; i < DEPTH; i++) begin : g_sel
      localparam logic [AW-1:0] IDX = AW'(i);
      assign sel_o[i] = &(~(addr_i ^ IDX));
   end

endmodule

// File: rtl/oblivious_write_bank.sv
// oblivious_write_bank: data-oblivious register bank with one-write-per-cycle pipeline and clear sweep
//   clk/rst            rising-edge clock, async active-high reset
//   wr_valid/wr_ready  write handshake; wr_addr, wr_data the write payload
//   wr_ack             pulses when a write is visible in bank
//   clear_req          level request to zero all entries; clear_done pulses at sweep end
//   bank               all entries, entry i at [i*WIDTH +: WIDTH]
module oblivious_write_bank
   import oblivious_write_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = aw_for(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   wr_ack,
   input  logic                   clear_req,
   output logic                   clear_done,
   output logic [DEPTH*WIDTH-1:0] bank
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t                 state_q, state_d;
   logic                   armed_q, armed_d;
   logic [AW-1:0]          cnt_q, cnt_d;
   logic                   s1_valid_q;
   logic [WIDTH-1:0]       s1_data_q;
   logic [DEPTH-1:0]       s1_sel_q;
   logic                   wr_ack_q, clear_done_q;
   logic [DEPTH*WIDTH-1:0] bank_q, bank_d;
   logic [DEPTH-1:0]       wr_sel, sw_sel, mask;
   logic [WIDTH-1:0]       upd_data;
   logic                   accept, sweeping;

   onehot_decode #(.AW(AW), .DEPTH(DEPTH)) u_wr_dec (.addr_i(wr_addr), .sel_o(wr_sel));
   onehot_decode #(.AW(AW), .DEPTH(DEPTH)) u_sw_dec (.addr_i(cnt_q),   .sel_o(sw_sel));

   assign wr_ready   = (state_q == IDLE) && !clear_req;
   assign accept     = wr_valid && wr_ready;
   assign sweeping   = (state_q == SWEEP);
   assign wr_ack     = wr_ack_q;
   assign clear_done = clear_done_q;
   assign bank       = bank_q;

   // The sweep reuses the write gate form with D=0; stage 1 is always empty during SWEEP.
   assign mask     = (s1_sel_q & {DEPTH{s1_valid_q}}) | (sw_sel & {DEPTH{sweeping}});
   assign upd_data = sweeping ? '0 : s1_data_q;

   always_comb begin
      bank_d = bank_q;
      for (int i = 0; i < DEPTH; i++)
         bank_d[i*WIDTH +: WIDTH] = ((upd_data ^ bank_q[i*WIDTH +: WIDTH]) & {WIDTH{mask[i]}})
                                    ^ bank_q[i*WIDTH +: WIDTH];
   end

   // armed_q blocks a second clear while clear_req stays high after DONE.
   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      cnt_d   = sweeping ? cnt_q + AW'(1) : '0;
      case (state_q)
         IDLE: begin
            armed_d = armed_q | !clear_req;
            state_d = (clear_req && armed_q) ? DRAIN : IDLE;
         end
         DRAIN: state_d = s1_valid_q ? DRAIN : SWEEP;
         SWEEP: state_d = (cnt_q == LAST) ? DONE : SWEEP;
         DONE: begin
            armed_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         armed_q      <= 1'b1;
         cnt_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_sel_q     <= '0;
         wr_ack_q     <= 1'b0;
         clear_done_q <= 1'b0;
         bank_q       <= '0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         s1_valid_q   <= accept;
         s1_data_q    <= wr_data;
         s1_sel_q     <= wr_sel;
         wr_ack_q     <= s1_valid_q;
         clear_done_q <= sweeping && (cnt_q == LAST);
         bank_q       <= bank_d;
      end
   end

endmodule

// File: tb/tb_oblivious_write_bank.sv
// tb_oblivious_write_bank: directed self-checking bench for oblivious_write_bank (DEPTH=4 and DEPTH=3)
module tb_oblivious_write_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, wr_ready, wr_ack, clear_req, clear_done;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [31:0] bank;
   logic        wr_valid3, wr_ready3, wr_ack3, clear_done3;
   logic [1:0]  wr_addr3;
   logic [7:0]  wr_data3;
   logic [23:0] bank3;
   int          checks = 0;
   int          errors = 0;
   int          pulses, first;

   always #5 clk = ~clk;

   oblivious_write_bank #(.WIDTH(8), .DEPTH(4), .AW(2)) u_dut4 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .clear_req(clear_req), .clear_done(clear_done),
      .bank(bank)
   );

   oblivious_write_bank #(.WIDTH(8), .DEPTH(3), .AW(2)) u_dut3 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_addr(wr_addr3),
      .wr_data(wr_data3), .wr_ack(wr_ack3), .clear_req(1'b0), .clear_done(clear_done3),
      .bank(bank3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
   endtask

   initial begin
      logic [31:0] sweep_exp [1:5];
      sweep_exp[1] = 32'h0403_0201;
      sweep_exp[2] = 32'h0403_0200;
      sweep_exp[3] = 32'h0403_0000;
      sweep_exp[4] = 32'h0400_0000;
      sweep_exp[5] = 32'h0000_0000;
      rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0; clear_req = 0;
      wr_valid3 = 0; wr_addr3 = 0; wr_data3 = 0;
      tick(); tick();
      check("rst_bank", bank, 32'h0);
      check("rst_ack", {31'b0, wr_ack}, 32'h0);
      check("rst_done", {31'b0, clear_done}, 32'h0);
      rst = 1'b0;
      tick();
      check("ready_after_rst", {31'b0, wr_ready}, 32'h1);

      // write after reset: one-cycle latency
      wr(2'd2, 8'hA5);
      tick();
      wr_valid = 1'b0;
      check("wr_lat_ack", {31'b0, wr_ack}, 32'h0);
      check("wr_lat_bank", bank, 32'h0);
      tick();
      check("wr_ack", {31'b0, wr_ack}, 32'h1);
      check("wr_bank", bank, 32'h00A5_0000);
      tick();
      check("wr_ack_pulse", {31'b0, wr_ack}, 32'h0);

      // back-to-back writes to the same entry
      wr(2'd1, 8'h11);
      tick();
      wr(2'd1, 8'h22);
      tick();
      wr_valid = 1'b0;
      check("b2b_ack1", {31'b0, wr_ack}, 32'h1);
      check("b2b_bank1", bank, 32'h00A5_1100);
      tick();
      check("b2b_ack2", {31'b0, wr_ack}, 32'h1);
      check("b2b_bank2", bank, 32'h00A5_2200);
      tick();
      check("b2b_ack_end", {31'b0, wr_ack}, 32'h0);

      // out-of-range address on DEPTH=3
      wr_valid3 = 1'b1; wr_addr3 = 2'd0; wr_data3 = 8'h3C;
      tick();
      wr_addr3 = 2'd3; wr_data3 = 8'hFF;
      tick();
      wr_valid3 = 1'b0;
      check("oor_prev_bank", {8'h0, bank3}, 32'h0000_003C);
      tick();
      check("oor_ack", {31'b0, wr_ack3}, 32'h1);
      check("oor_bank", {8'h0, bank3}, 32'h0000_003C);

      // clear while a write is in flight
      wr(2'd0, 8'h01); tick();
      wr(2'd1, 8'h02); tick();
      wr(2'd2, 8'h03); tick();
      wr(2'd3, 8'h04); tick();
      wr(2'd0, 8'hEE);
      clear_req = 1'b1;
      #1;
      check("clr_ready0", {31'b0, wr_ready}, 32'h0);
      tick();
      wr_valid = 1'b0;
      check("clr_inflight_ack", {31'b0, wr_ack}, 32'h1);
      check("clr_inflight_bank", bank, 32'h0403_0201);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("clr_bank_%0d", k), bank, sweep_exp[k]);
         check($sformatf("clr_done_%0d", k), {31'b0, clear_done}, (k == 5) ? 32'h1 : 32'h0);
         check($sformatf("clr_ready_%0d", k), {31'b0, wr_ready}, 32'h0);
         if (k == 1) check("clr_no_accept", {31'b0, wr_ack}, 32'h0);
      end
      pulses = 0;
      for (int k = 6; k <= 9; k++) begin
         tick();
         if (clear_done) pulses++;
         check($sformatf("clr_hold_ready_%0d", k), {31'b0, wr_ready}, 32'h0);
      end
      check("clr_hold_no_repeat", pulses, 0);
      clear_req = 1'b0;
      tick();
      check("clr_ready_back", {31'b0, wr_ready}, 32'h1);

      // held clear_req from IDLE: one pulse, 6 edges after assertion
      clear_req = 1'b1;
      pulses = 0;
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (clear_done) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      check("held_pulses", pulses, 1);
      check("held_latency", first, 6);
      clear_req = 1'b0;
      tick();

      // async reset mid-sweep
      wr(2'd1, 8'h77);
      tick();
      wr_valid = 1'b0;
      tick();
      check("pre_rst_bank", bank, 32'h0000_7700);
      clear_req = 1'b1;
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      check("midsweep_rst_bank", bank, 32'h0);
      check("midsweep_rst_done", {31'b0, clear_done}, 32'h0);
      clear_req = 1'b0;
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (clear_done) pulses++;
      end
      check("post_rst_no_done", pulses, 0);
      check("post_rst_ready", {31'b0, wr_ready}, 32'h1);
      check("post_rst_bank", bank, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
